// File: rtl/lsu_bus_master.sv
// Load/store bus master: turns one pipeline access into one or two word beats
// on a variable-latency memory port and returns reassembled, extended load data.
module lsu_bus_master #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [2:0]        cpu_rw_type,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_done,
   output logic [31:0]       cpu_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ0, REQ1, RESP} state_t;

   state_t      state;
   logic        we_q;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        ext_q;
   logic        split_q;
   logic [3:0]  be_hi_q;
   logic [31:0] wdata_hi_q;
   logic [31:0] rdata0_q;

   logic [7:0]  lanes;
   logic [7:0]  mask;
   logic [63:0] wshift;

   // Two-word lane mask and write data for the access being offered.
   always_comb begin
      case (cpu_rw_type[1:0])
         2'b00:   lanes = 8'h01;
         2'b01:   lanes = 8'h03;
         default: lanes = 8'h0F;
      endcase
      mask   = lanes << cpu_addr[1:0];
      wshift = {32'b0, cpu_wdata} << {cpu_addr[1:0], 3'b000};
   end

   function automatic logic [31:0] fmt_load(input logic [63:0] r, input logic [1:0] off,
                                            input logic [1:0] size, input logic ext);
      logic [31:0] s;
      s = 32'(r >> {off, 3'b000});
      case (size)
         2'b00:   fmt_load = ext ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         2'b01:   fmt_load = ext ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: fmt_load = s;
      endcase
   endfunction

   // Handshake flags are decoded from the state so reset drops them at once.
   assign mem_req   = (state == REQ0) || (state == REQ1);
   assign cpu_done  = (state == RESP);
   assign cpu_stall = !rst && (mem_req || ((state == IDLE) && cpu_req));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         off_q      <= 2'b00;
         size_q     <= 2'b00;
         ext_q      <= 1'b0;
         split_q    <= 1'b0;
         be_hi_q    <= 4'b0;
         wdata_hi_q <= 32'b0;
         rdata0_q   <= 32'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= 4'b0;
         mem_wdata  <= 32'b0;
         cpu_rdata  <= 32'b0;
      end else begin
         case (state)
            IDLE: if (cpu_req) begin
               state      <= REQ0;
               we_q       <= cpu_we;
               off_q      <= cpu_addr[1:0];
               size_q     <= cpu_rw_type[1:0];
               ext_q      <= cpu_rw_type[2];
               split_q    <= |mask[7:4];
               be_hi_q    <= mask[7:4];
               wdata_hi_q <= wshift[63:32];
               mem_we     <= cpu_we;
               mem_addr   <= {cpu_addr[ADDR_W-1:2], 2'b00};
               mem_be     <= mask[3:0];
               mem_wdata  <= wshift[31:0];
            end
            REQ0: if (mem_ack) begin
               if (split_q) begin
                  state     <= REQ1;
                  rdata0_q  <= mem_rdata;
                  mem_addr  <= mem_addr + ADDR_W'(4);
                  mem_be    <= be_hi_q;
                  mem_wdata <= wdata_hi_q;
               end else begin
                  state     <= RESP;
                  cpu_rdata <= we_q ? 32'b0 : fmt_load({32'b0, mem_rdata}, off_q, size_q, ext_q);
               end
            end
            REQ1: if (mem_ack) begin
               state     <= RESP;
               cpu_rdata <= we_q ? 32'b0 : fmt_load({mem_rdata, rdata0_q}, off_q, size_q, ext_q);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized bench for lsu_bus_master: a byte-level model predicts every beat,
// the cycle-exact handshake and the returned load data.
module tb_lsu_bus_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b1;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = 32'b0;
   logic [2:0]  cpu_rw_type = 3'b0;
   logic [31:0] cpu_wdata = 32'b0;
   logic        cpu_stall, cpu_done;
   logic [31:0] cpu_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'b0;

   lsu_bus_master #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_rw_type(cpu_rw_type), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Expected DUT outputs for the coming falling edge.
   logic        exp_req = 1'b0, exp_stall = 1'b0, exp_done = 1'b0, exp_we = 1'b0;
   logic [31:0] exp_addr = 32'b0, exp_wdata = 32'b0, exp_rdata = 32'b0;
   logic [3:0]  exp_be = 4'b0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lane_bits(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   // Per-cycle comparison against the model's expectations.
   always @(negedge clk) begin
      cmp("mem_req", 32'(mem_req), 32'(exp_req));
      cmp("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
      cmp("cpu_done", 32'(cpu_done), 32'(exp_done));
      cmp("mem_addr", mem_addr, exp_addr);
      cmp("mem_be", 32'(mem_be), 32'(exp_be));
      cmp("mem_we", 32'(mem_we), 32'(exp_we));
      cmp("mem_wdata", mem_wdata & lane_bits(exp_be), exp_wdata & lane_bits(exp_be));
      cmp("cpu_rdata", cpu_rdata, exp_rdata);
   end

   // Byte-by-byte model: each accessed byte address maps to a word beat and lane.
   task automatic model(input logic [31:0] a, input logic [2:0] rwt, input logic [31:0] wd,
                        input logic [31:0] r0, input logic [31:0] r1,
                        output logic [31:0] a0, output logic [31:0] a1,
                        output logic [3:0] be0, output logic [3:0] be1,
                        output logic [31:0] wd0, output logic [31:0] wd1,
                        output int nb, output logic [31:0] rv);
      logic [31:0] rd [2];
      logic [31:0] wdw [2];
      logic [3:0]  be [2];
      logic [31:0] ba;
      int n, b, lane;
      n = (rwt[1:0] == 2'b00) ? 1 : (rwt[1:0] == 2'b01) ? 2 : 4;
      a0 = a & 32'hFFFF_FFFC;
      a1 = a0 + 32'd4;
      rd[0] = r0; rd[1] = r1;
      wdw[0] = 32'b0; wdw[1] = 32'b0;
      be[0] = 4'b0; be[1] = 4'b0;
      rv = 32'b0;
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         b = ((ba & 32'hFFFF_FFFC) == a0) ? 0 : 1;
         lane = int'(ba[1:0]);
         be[b][lane] = 1'b1;
         wdw[b][lane*8 +: 8] = wd[i*8 +: 8];
         rv[i*8 +: 8] = rd[b][lane*8 +: 8];
      end
      if (n < 4 && !rwt[2] && rv[8*n-1]) rv = rv | (32'hFFFF_FFFF << (8*n));
      be0 = be[0]; be1 = be[1];
      wd0 = wdw[0]; wd1 = wdw[1];
      nb = (be[1] != 4'b0) ? 2 : 1;
   endtask

   // One transaction, driven just after the rising edge; optional reset in beat 1.
   task automatic run_txn(input logic [31:0] a, input logic we, input logic [2:0] rwt,
                          input logic [31:0] wd, input logic [31:0] r0, input logic [31:0] r1,
                          input int w0, input int w1, input bit abort);
      logic [31:0] a0, a1, wd0, wd1, rv;
      logic [3:0]  be0, be1;
      int nb, w;
      model(a, rwt, wd, r0, r1, a0, a1, be0, be1, wd0, wd1, nb, rv);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_rw_type = rwt; cpu_wdata = wd;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      exp_req = 1'b0; exp_stall = 1'b1; exp_done = 1'b0;
      @(posedge clk); #1;
      for (int b = 0; b < nb; b++) begin
         w = (b == 0) ? w0 : w1;
         for (int k = 0; k <= w; k++) begin
            cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = $urandom; cpu_rw_type = 3'($urandom_range(0, 7)); cpu_wdata = $urandom;
            exp_req = 1'b1; exp_stall = 1'b1; exp_done = 1'b0; exp_we = we;
            exp_addr = (b == 0) ? a0 : a1;
            exp_be = (b == 0) ? be0 : be1;
            exp_wdata = (b == 0) ? wd0 : wd1;
            if (abort && b == 1) begin
               mem_ack = 1'b0;
               @(posedge clk); #2;
               rst = 1'b1; cpu_req = 1'b1;
               #1;
               cmp("rst_mem_req", 32'(mem_req), 32'd0);
               cmp("rst_cpu_stall", 32'(cpu_stall), 32'd0);
               cmp("rst_cpu_done", 32'(cpu_done), 32'd0);
               exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b0; exp_we = 1'b0;
               exp_addr = 32'b0; exp_be = 4'b0; exp_wdata = 32'b0; exp_rdata = 32'b0;
               @(posedge clk); #1;
               rst = 1'b0; cpu_req = 1'b0;
               @(posedge clk); #1;
               return;
            end
            mem_ack = (k == w);
            mem_rdata = (k == w) ? ((b == 0) ? r0 : r1) : $urandom;
            @(posedge clk); #1;
         end
      end
      exp_req = 1'b0; exp_stall = 1'b0; exp_done = 1'b1;
      exp_rdata = we ? 32'b0 : rv;
      cpu_req = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cpu_req = 1'b0; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      exp_done = 1'b0; exp_stall = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a0, a1, wd0, wd1, rv, ra;
      logic [3:0]  be0, be1;
      logic        we;
      int nb;

      // Reset held with a pending request: everything stays zero.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; cpu_req = 1'b0;
      @(posedge clk); #1;

      // Pin the model with hand-derived values.
      model(32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, a0, a1, be0, be1, wd0, wd1, nb, rv);
      cmp("model_lw_be", 32'(be0), 32'hF);
      cmp("model_lw_rdata", rv, 32'hDEADBEEF);
      model(32'h203, 3'b000, 32'hA5, 32'h0, 32'h0, a0, a1, be0, be1, wd0, wd1, nb, rv);
      cmp("model_sb_addr", a0, 32'h200);
      cmp("model_sb_be", 32'(be0), 32'h8);
      cmp("model_sb_byte", 32'(wd0[31:24]), 32'hA5);
      cmp("model_sb_beats", 32'(nb), 32'd1);
      model(32'h101, 3'b000, 32'h0, 32'h1234F056, 32'h0, a0, a1, be0, be1, wd0, wd1, nb, rv);
      cmp("model_lb", rv, 32'hFFFFFFF0);
      model(32'h101, 3'b100, 32'h0, 32'h1234F056, 32'h0, a0, a1, be0, be1, wd0, wd1, nb, rv);
      cmp("model_lbu", rv, 32'h000000F0);
      model(32'h102, 3'b010, 32'h0, 32'hAABBCCDD, 32'h11223344, a0, a1, be0, be1, wd0, wd1, nb, rv);
      cmp("model_split_be0", 32'(be0), 32'hC);
      cmp("model_split_be1", 32'(be1), 32'h3);
      cmp("model_split_a1", a1, 32'h104);
      cmp("model_split_rdata", rv, 32'h3344AABB);
      model(32'hFFFFFFFF, 3'b001, 32'hBEEF, 32'h0, 32'h0, a0, a1, be0, be1, wd0, wd1, nb, rv);
      cmp("model_wrap_a0", a0, 32'hFFFFFFFC);
      cmp("model_wrap_a1", a1, 32'h0);
      cmp("model_wrap_be", {24'b0, be1, be0}, 32'h18);
      cmp("model_wrap_bytes", {16'b0, wd1[7:0], wd0[31:24]}, 32'hBEEF);

      // Directed transactions from the plan.
      run_txn(32'h100, 1'b0, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
      cmp("lw_rdata", cpu_rdata, 32'hDEADBEEF);
      run_txn(32'h203, 1'b1, 3'b000, 32'h000000A5, 32'h0, 32'h0, 1, 0, 1'b0);
      cmp("sb_addr", mem_addr, 32'h200);
      cmp("sb_be", 32'(mem_be), 32'h8);
      cmp("sb_byte", 32'(mem_wdata[31:24]), 32'hA5);
      run_txn(32'h101, 1'b0, 3'b000, 32'h0, 32'h1234F056, 32'h0, 0, 0, 1'b0);
      cmp("lb_rdata", cpu_rdata, 32'hFFFFFFF0);
      run_txn(32'h101, 1'b0, 3'b100, 32'h0, 32'h1234F056, 32'h0, 0, 0, 1'b0);
      cmp("lbu_rdata", cpu_rdata, 32'h000000F0);
      run_txn(32'h102, 1'b0, 3'b010, 32'h0, 32'hAABBCCDD, 32'h11223344, 2, 2, 1'b0);
      cmp("split_rdata", cpu_rdata, 32'h3344AABB);
      run_txn(32'hFFFFFFFF, 1'b1, 3'b001, 32'h0000BEEF, 32'h0, 32'h0, 0, 1, 1'b0);
      cmp("wrap_addr", mem_addr, 32'h0);
      cmp("wrap_byte", 32'(mem_wdata[7:0]), 32'hBE);
      run_txn(32'h102, 1'b0, 3'b010, 32'h0, 32'h55667788, 32'h99AABBCC, 0, 0, 1'b1);
      run_txn(32'h10, 1'b0, 3'b101, 32'h0, 32'h8001FFFF, 32'h0, 0, 0, 1'b0);
      cmp("lhu_rdata", cpu_rdata, 32'h0000FFFF);

      // Random traffic, biased toward the top of the address space.
      for (int t = 0; t < 300; t++) begin
         ra = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
         we = 1'($urandom_range(0, 1));
         run_txn(ra, we, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
